instr_fetcher: RTL and testbench

Instruction fetch stage sitting directly upstream of the memory controller's instruction-fetch port and downstream-feeding the instruction queue. It holds the PC and looks it up in a direct-mapped, one-word-per-line instruction cache. On a hit it delivers one instruction per cycle to the queue. On a miss it issues a single word fetch to the memory controller, fills the line, and resumes. A mispredict or flush (`clear_flag_in`) redirects the PC and drops any in-flight fetch.

---
 rtl/instr_fetcher.sv | 162 ++++++++++++++++
 tb/tb_instr_fetcher.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetch stage with a direct-mapped one-word-per-line I-cache
//
// Purpose:
//   Holds the fetch PC and looks it up in a direct-mapped instruction cache
//   with one 32-bit word per line. A hit issues one instruction per cycle to
//   the instruction queue. A miss issues a single word fetch to the memory
//   controller, fills the line when the word returns, and the following IDLE
//   cycle hits on the new line. A clear redirects the PC and abandons any
//   fetch in flight.
//
// Ports:
//   clk                  in   clock, rising edge
//   rst                  in   synchronous active-low reset
//   rdy                  in   global ready; low freezes all state
//   clear_flag_in        in   flush/redirect request
//   clear_pc_in          in   redirect target PC
//   mc_fetch_enable_out  out  one-cycle fetch request to the memory controller
//   mc_addr_out          out  fetch address, stable while the fetch is pending
//   mc_result_enable_in  in   fetched word valid (one-cycle pulse)
//   mc_data_in           in   fetched word
//   iq_full_in           in   instruction queue cannot accept this cycle
//   iq_enable_out        out  instruction valid (one-cycle pulse)
//   iq_instr_out         out  instruction word
//   iq_pc_out            out  PC of iq_instr_out
module instr_fetcher #(
  parameter int ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  input  logic [31:0] clear_pc_in,
  output logic        mc_fetch_enable_out,
  output logic [31:0] mc_addr_out,
  input  logic        mc_result_enable_in,
  input  logic [31:0] mc_data_in,
  input  logic        iq_full_in,
  output logic        iq_enable_out,
  output logic [31:0] iq_instr_out,
  output logic [31:0] iq_pc_out
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } stat_e;

  stat_e                   stat_q, stat_d;
  logic [31:0]             pc_q, pc_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];

  logic                    iq_en_q, iq_en_d;
  logic [31:0]             iq_instr_q, iq_instr_d;
  logic [31:0]             iq_pc_q, iq_pc_d;
  logic                    mc_en_q, mc_en_d;
  logic [31:0]             mc_addr_q, mc_addr_d;

  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        pc_tag;
  logic                    hit;
  logic                    fill_we;

  // The PC stays put for the whole miss, so the fill lands on the line
  // addressed by the current PC without needing a separate fill address.
  assign idx    = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag = pc_q[31:ICACHE_IDX_W+2];
  assign hit    = valid_q[idx] && (tag_q[idx] == pc_tag);

  always_comb begin
    stat_d     = stat_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    iq_en_d    = 1'b0;
    iq_instr_d = iq_instr_q;
    iq_pc_d    = iq_pc_q;
    mc_en_d    = 1'b0;
    mc_addr_d  = mc_addr_q;
    fill_we    = 1'b0;

    if (!rdy) begin
      // Frozen: only the two pulses drop, everything else holds.
      iq_en_d = 1'b0;
      mc_en_d = 1'b0;
    end else if (clear_flag_in) begin
      // Redirect wins over issue, request and fill; a result arriving in
      // the same cycle belongs to the abandoned fetch and is dropped.
      pc_d   = clear_pc_in & 32'hFFFF_FFFC;
      stat_d = IDLE;
    end else begin
      unique case (stat_q)
        IDLE: begin
          if (!iq_full_in) begin
            if (hit) begin
              iq_en_d    = 1'b1;
              iq_instr_d = data_q[idx];
              iq_pc_d    = pc_q;
              pc_d       = pc_q + 32'd4;
            end else begin
              mc_en_d   = 1'b1;
              mc_addr_d = pc_q;
              stat_d    = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // The word is only written to the cache; it is issued by the
          // hit path on the next IDLE cycle.
          if (mc_result_enable_in) begin
            fill_we      = 1'b1;
            valid_d[idx] = 1'b1;
            stat_d       = IDLE;
          end
        end
        default: begin
          stat_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q     <= IDLE;
      pc_q       <= 32'd0;
      valid_q    <= '0;
      iq_en_q    <= 1'b0;
      iq_instr_q <= 32'd0;
      iq_pc_q    <= 32'd0;
      mc_en_q    <= 1'b0;
      mc_addr_q  <= 32'd0;
    end else begin
      stat_q     <= stat_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      iq_en_q    <= iq_en_d;
      iq_instr_q <= iq_instr_d;
      iq_pc_q    <= iq_pc_d;
      mc_en_q    <= mc_en_d;
      mc_addr_q  <= mc_addr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rst && fill_we) begin
      data_q[idx] <= mc_data_in;
      tag_q[idx]  <= pc_tag;
    end
  end

  assign mc_fetch_enable_out = mc_en_q;
  assign mc_addr_out         = mc_addr_q;
  assign iq_enable_out       = iq_en_q;
  assign iq_instr_out        = iq_instr_q;
  assign iq_pc_out           = iq_pc_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - self-checking bench for instr_fetcher
module tb_instr_fetcher;

  localparam int K = 5;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear_flag_in;
  logic [31:0] clear_pc_in;
  logic        mc_fetch_enable_out;
  logic [31:0] mc_addr_out;
  logic        mc_result_enable_in;
  logic [31:0] mc_data_in;
  logic        iq_full_in;
  logic        iq_enable_out;
  logic [31:0] iq_instr_out;
  logic [31:0] iq_pc_out;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          req_cnt  = 0;
  int          iss_cnt  = 0;
  int          cyc      = 0;
  int          iss_cyc[$];
  logic [31:0] exp_req[$];
  logic [63:0] exp_iq[$];

  logic        mem_auto;
  logic        manual_fire;
  logic [31:0] manual_data;

  instr_fetcher #(.ICACHE_IDX_W(6)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .clear_flag_in       (clear_flag_in),
    .clear_pc_in         (clear_pc_in),
    .mc_fetch_enable_out (mc_fetch_enable_out),
    .mc_addr_out         (mc_addr_out),
    .mc_result_enable_in (mc_result_enable_in),
    .mc_data_in          (mc_data_in),
    .iq_full_in          (iq_full_in),
    .iq_enable_out       (iq_enable_out),
    .iq_instr_out        (iq_instr_out),
    .iq_pc_out           (iq_pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_iq(input logic [31:0] pc);
    exp_iq.push_back({pc, mem_word(pc)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int n);
    int t = 0;
    while (req_cnt < n && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("req_count_reached", req_cnt, n);
  endtask

  // Redirect while stalled, then release the queue on the cycle after.
  task automatic redirect(input logic [31:0] pc);
    clear_flag_in = 1'b1;
    clear_pc_in   = pc;
    @(posedge clk);
    #1;
    clear_flag_in = 1'b0;
    iq_full_in    = 1'b0;
  endtask

  // Memory controller model: fixed latency K, drops pending fetch on clear.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] addr;
    pend = 1'b0;
    cnt  = 0;
    addr = 32'd0;
    mc_result_enable_in = 1'b0;
    mc_data_in          = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      mc_result_enable_in = 1'b0;
      if (mc_fetch_enable_out && mem_auto) begin
        pend = 1'b1;
        cnt  = K - 1;
        addr = mc_addr_out;
      end else if (clear_flag_in) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          mc_result_enable_in = 1'b1;
          mc_data_in          = mem_word(addr);
        end
      end
      if (manual_fire) begin
        mc_result_enable_in = 1'b1;
        mc_data_in          = manual_data;
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    logic        outst;
    logic [31:0] oaddr;
    logic [63:0] e;
    logic [31:0] ea;
    outst = 1'b0;
    oaddr = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (iq_enable_out) begin
          iss_cnt++;
          iss_cyc.push_back(cyc);
          if (exp_iq.size() == 0) begin
            check("iq_unexpected_pulse", {31'b0, iq_enable_out}, 32'd0);
          end else begin
            e = exp_iq.pop_front();
            check("iq_pc", iq_pc_out, e[63:32]);
            check("iq_instr", iq_instr_out, e[31:0]);
          end
        end
        if (mc_fetch_enable_out) begin
          req_cnt++;
          check("req_while_outstanding", {31'b0, outst}, 32'd0);
          if (exp_req.size() == 0) begin
            check("req_unexpected_pulse", {31'b0, mc_fetch_enable_out}, 32'd0);
          end else begin
            ea = exp_req.pop_front();
            check("mc_addr", mc_addr_out, ea);
          end
          outst = 1'b1;
          oaddr = mc_addr_out;
        end else if (outst) begin
          check("mc_addr_hold", mc_addr_out, oaddr);
          if (mc_result_enable_in || clear_flag_in) outst = 1'b0;
        end
      end
    end
  end

  initial begin
    int b;
    int r;
    rst           = 1'b0;
    rdy           = 1'b1;
    clear_flag_in = 1'b0;
    clear_pc_in   = 32'd0;
    iq_full_in    = 1'b0;
    mem_auto      = 1'b1;
    manual_fire   = 1'b0;
    manual_data   = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iq_enable", {31'b0, iq_enable_out}, 32'd0);
    check("rst_mc_enable", {31'b0, mc_fetch_enable_out}, 32'd0);
    check("rst_mc_addr", mc_addr_out, 32'd0);
    check("rst_iq_instr", iq_instr_out, 32'd0);
    check("rst_iq_pc", iq_pc_out, 32'd0);

    // Cold start: every line misses; word at 0x0 is 0x00000013
    exp_req.push_back(32'h0);  push_iq(32'h0);
    exp_req.push_back(32'h4);  push_iq(32'h4);
    exp_req.push_back(32'h8);  push_iq(32'h8);
    exp_req.push_back(32'hC);  push_iq(32'hC);
    exp_req.push_back(32'h10);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_req(5);
    iq_full_in = 1'b1;
    tick(12);
    check("cold_issues", iss_cnt, 4);

    // Warm loop: four back-to-back hits, no memory traffic
    b = iss_cnt; r = req_cnt;
    push_iq(32'h0); push_iq(32'h4); push_iq(32'h8); push_iq(32'hC);
    redirect(32'h0);
    tick(4);
    iq_full_in = 1'b1;
    tick(4);
    check("warm_issues", iss_cnt - b, 4);
    check("warm_no_req", req_cnt, r);
    if (iss_cyc.size() >= b + 4) check("warm_back_to_back", iss_cyc[b+3] - iss_cyc[b], 3);

    // Backpressure: full for 3 cycles after two hits
    b = iss_cnt;
    push_iq(32'h0); push_iq(32'h4); push_iq(32'h8); push_iq(32'hC);
    redirect(32'h0);
    tick(2);
    iq_full_in = 1'b1;
    tick(3);
    check("bp_stalled", iss_cnt - b, 2);
    iq_full_in = 1'b0;
    tick(2);
    iq_full_in = 1'b1;
    tick(3);
    check("bp_total", iss_cnt - b, 4);
    check("bp_no_req", req_cnt, r);
    if (iss_cyc.size() >= b + 3) check("bp_gap", iss_cyc[b+2] - iss_cyc[b+1], 4);

    // rdy low for 4 cycles mid-stream
    b = iss_cnt;
    push_iq(32'h0); push_iq(32'h4); push_iq(32'h8); push_iq(32'hC);
    redirect(32'h0);
    tick(2);
    rdy = 1'b0;
    tick(4);
    check("rdy_frozen", iss_cnt - b, 2);
    rdy = 1'b1;
    tick(2);
    iq_full_in = 1'b1;
    tick(3);
    check("rdy_total", iss_cnt - b, 4);
    check("rdy_no_req", req_cnt, r);
    if (iss_cyc.size() >= b + 3) check("rdy_gap", iss_cyc[b+2] - iss_cyc[b+1], 5);

    // Conflict miss: 0x100 evicts 0x0, which then misses again
    exp_req.push_back(32'h100); push_iq(32'h100); exp_req.push_back(32'h104);
    redirect(32'h100);
    wait_req(r + 2);
    iq_full_in = 1'b1;
    tick(12);
    exp_req.push_back(32'h0); push_iq(32'h0); exp_req.push_back(32'h4);
    redirect(32'h0);
    wait_req(r + 4);
    iq_full_in = 1'b1;
    tick(12);

    // PC wrap: 0xFFFFFFFC then 0x0.. hit out of lines 0..4
    r = req_cnt; b = iss_cnt;
    exp_req.push_back(32'hFFFF_FFFC);
    push_iq(32'hFFFF_FFFC);
    push_iq(32'h0); push_iq(32'h4); push_iq(32'h8); push_iq(32'hC); push_iq(32'h10);
    exp_req.push_back(32'h14);
    redirect(32'hFFFF_FFFC);
    wait_req(r + 2);
    iq_full_in = 1'b1;
    tick(12);
    check("wrap_issues", iss_cnt - b, 6);

    // Clear mid-miss with a coincident result that must be discarded
    r = req_cnt; b = iss_cnt;
    mem_auto = 1'b0;
    exp_req.push_back(32'h40);
    redirect(32'h40);
    wait_req(r + 1);
    tick(2);
    exp_req.push_back(32'h200); push_iq(32'h200); exp_req.push_back(32'h204);
    clear_flag_in = 1'b1;
    clear_pc_in   = 32'h200;
    manual_fire   = 1'b1;
    manual_data   = 32'hBAD0_0BAD;
    mem_auto      = 1'b1;
    @(posedge clk);
    #1;
    clear_flag_in = 1'b0;
    manual_fire   = 1'b0;
    wait_req(r + 3);
    iq_full_in = 1'b1;
    tick(12);
    check("midclr_issues", iss_cnt - b, 1);
    exp_req.push_back(32'h40); push_iq(32'h40); exp_req.push_back(32'h44);
    redirect(32'h40);
    wait_req(r + 5);
    iq_full_in = 1'b1;
    tick(12);

    check("iq_queue_drained", exp_iq.size(), 0);
    check("req_queue_drained", exp_req.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
